uart_tx_unit: RTL and testbench

- UART transmitter for the EE417 UART lab; the companion to the receiver control unit.
- Combines the control FSM and datapath: a data register, a frame shift register, a sample counter and a bit counter.
- Serializes one word_size-bit byte per frame: start 0, data LSB first, stop 1.
- Each bit is held for OVERSAMPLE clocks of the same Sample_clk the receiver samples on.
- Sits between the host bus and the serial line feeding the Rx.

---
 rtl/uart_tx_unit.sv | 130 +++++++++++++
 tb/tb_uart_tx_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: control FSM plus datapath (data register, frame shift
// register, sample counter, bit counter). Frames are start(0), data LSB
// first, stop(1); each bit is held for OVERSAMPLE Sample_clk cycles.
module uart_tx_unit #(
    parameter int word_size      = 8,
    parameter int OVERSAMPLE     = 8,
    parameter int SC_bits        = 3,
    parameter int BC_bits        = 4,
    parameter int Num_state_bits = 2
) (
    input  logic                 Sample_clk,
    input  logic                 rst,
    input  logic [word_size-1:0] Data_Bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    input  logic                 T_byte,
    output logic                 Serial_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [Num_state_bits-1:0] {
        IDLE    = 'd0,
        WAITING = 'd1,
        SENDING = 'd2
    } state_t;

    localparam logic [SC_bits-1:0] SC_LAST  = SC_bits'(OVERSAMPLE - 1);
    localparam logic [BC_bits-1:0] BC_STOP  = BC_bits'(word_size + 1);

    state_t               state, next_state;
    logic [word_size-1:0] XMT_datareg;
    logic [word_size:0]   XMT_shftreg;
    logic [SC_bits-1:0]   sample_count;
    logic [BC_bits-1:0]   bit_count;

    logic load_data;
    logic load_shftreg;
    logic start_frame;
    logic shift_bit;
    logic clr_counters;
    logic inc_sample;
    logic done_set;

    // Next-state and datapath control decode
    always_comb begin
        next_state   = state;
        load_data    = 1'b0;
        load_shftreg = 1'b0;
        start_frame  = 1'b0;
        shift_bit    = 1'b0;
        clr_counters = 1'b0;
        inc_sample   = 1'b0;
        done_set     = 1'b0;
        case (state)
            IDLE: begin
                load_data = Load_XMT_datareg;
                if (Byte_ready) begin
                    load_shftreg = 1'b1;
                    next_state   = WAITING;
                end
            end
            WAITING: begin
                load_data = Load_XMT_datareg;
                if (T_byte) begin
                    start_frame  = 1'b1;
                    clr_counters = 1'b1;
                    next_state   = SENDING;
                end
            end
            SENDING: begin
                if (sample_count == SC_LAST) begin
                    if (bit_count < BC_STOP) begin
                        shift_bit = 1'b1;
                    end else begin
                        clr_counters = 1'b1;
                        done_set     = 1'b1;
                        next_state   = IDLE;
                    end
                end else begin
                    inc_sample = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Sample_clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Host data register; the shift register load sees the pre-edge value
    always_ff @(posedge Sample_clk) begin
        if (rst)            XMT_datareg <= '0;
        else if (load_data) XMT_datareg <= Data_Bus;
    end

    // Frame shift register: LSB drives the line, ones fill from the MSB
    always_ff @(posedge Sample_clk) begin
        if (rst)               XMT_shftreg <= '1;
        else if (load_shftreg) XMT_shftreg <= {XMT_datareg, 1'b1};
        else if (start_frame)  XMT_shftreg[0] <= 1'b0;
        else if (shift_bit)    XMT_shftreg <= {1'b1, XMT_shftreg[word_size:1]};
    end

    // Sample and bit counters
    always_ff @(posedge Sample_clk) begin
        if (rst || clr_counters) begin
            sample_count <= '0;
            bit_count    <= '0;
        end else if (shift_bit) begin
            sample_count <= '0;
            bit_count    <= bit_count + 1'b1;
        end else if (inc_sample) begin
            sample_count <= sample_count + 1'b1;
        end
    end

    // One-cycle completion pulse, registered on the edge entering idle
    always_ff @(posedge Sample_clk) begin
        if (rst) done <= 1'b0;
        else     done <= done_set;
    end

    assign Serial_out = XMT_shftreg[0];
    assign busy       = (state == SENDING);

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: directed and random frames compared
// against an ideal frame model and a mid-bit sampling receiver.
module tb_uart_tx_unit;

    localparam int WS = 8;
    localparam int OS = 8;
    localparam int FRAME_CYCLES = (WS + 2) * OS;

    logic          Sample_clk;
    logic          rst;
    logic [WS-1:0] Data_Bus;
    logic          Load_XMT_datareg;
    logic          Byte_ready;
    logic          T_byte;
    logic          Serial_out;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    uart_tx_unit #(
        .word_size(WS),
        .OVERSAMPLE(OS),
        .SC_bits(3),
        .BC_bits(4),
        .Num_state_bits(2)
    ) dut (
        .Sample_clk(Sample_clk),
        .rst(rst),
        .Data_Bus(Data_Bus),
        .Load_XMT_datareg(Load_XMT_datareg),
        .Byte_ready(Byte_ready),
        .T_byte(T_byte),
        .Serial_out(Serial_out),
        .busy(busy),
        .done(done)
    );

    initial begin
        Sample_clk = 1'b0;
        forever #5 Sample_clk = ~Sample_clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Sample_clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        check1({tag, "_serial"}, Serial_out, 1'b1);
        check1({tag, "_busy"},   busy,       1'b0);
        check1({tag, "_done"},   done,       1'b0);
    endtask

    task automatic load_byte(input logic [7:0] d);
        Data_Bus = d;
        Load_XMT_datareg = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
    endtask

    // Byte_ready for one edge; line must still idle and done must be low
    task automatic arm();
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        idle_outputs("arm");
    endtask

    // kind: 0 none, 1 Load 8'h00 mid-frame, 2 T_byte pulse mid-frame, 3 reset
    task automatic launch(input logic [7:0] d, input int kind, input int at_k);
        logic [WS+1:0] frame;
        logic [WS+1:0] rx_bits;
        frame   = {1'b1, d, 1'b0};
        rx_bits = '0;
        T_byte  = 1'b1;
        tick();
        T_byte  = 1'b0;
        for (int k = 0; k < FRAME_CYCLES; k++) begin
            if (k > 0) begin
                tick();
                Load_XMT_datareg = 1'b0;
                T_byte = 1'b0;
            end
            check1("frame_serial", Serial_out, frame[k / OS]);
            check1("frame_busy",   busy,       1'b1);
            check1("frame_done",   done,       1'b0);
            if (k % OS == OS / 2) rx_bits[k / OS] = Serial_out;
            if (k == at_k) begin
                case (kind)
                    1: begin Data_Bus = 8'h00; Load_XMT_datareg = 1'b1; end
                    2: T_byte = 1'b1;
                    3: begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        idle_outputs("midreset");
                        return;
                    end
                    default: ;
                endcase
            end
        end
        tick();
        check1("end_done",   done,       1'b1);
        check1("end_busy",   busy,       1'b0);
        check1("end_serial", Serial_out, 1'b1);
        check1("rx_start",   rx_bits[0],      1'b0);
        check1("rx_stop",    rx_bits[WS+1],   1'b1);
        check8("rx_byte",    rx_bits[WS:1],   d);
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        Data_Bus = '0;
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b1;
        T_byte = 1'b0;

        // Reset with control inputs toggling
        tick();
        idle_outputs("reset1");
        Byte_ready = 1'b0;
        T_byte = 1'b1;
        tick();
        idle_outputs("reset2");
        rst = 1'b0;
        T_byte = 1'b0;

        // Data register resets to zero
        arm();
        launch(8'h00, 0, -1);

        // Single frame 8'hA5
        load_byte(8'hA5);
        arm();
        launch(8'hA5, 0, -1);

        // Load and Byte_ready together: old register contents are framed
        load_byte(8'h3C);
        Data_Bus = 8'hFF;
        Load_XMT_datareg = 1'b1;
        Byte_ready = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready = 1'b0;
        idle_outputs("same_cycle");
        launch(8'h3C, 0, -1);
        arm();
        launch(8'hFF, 0, -1);

        // Load ignored while sending; the register keeps 8'hC3
        load_byte(8'hC3);
        arm();
        launch(8'hC3, 1, 37);
        arm();
        launch(8'hC3, 2, 45);

        // Reset during bit 4 of 8'h55, then a clean 8'h81 frame
        load_byte(8'h55);
        arm();
        launch(8'h55, 3, 4 * OS + 2);
        load_byte(8'h81);
        arm();
        launch(8'h81, 0, -1);

        // Back-to-back 8'h5A then 8'hF0, re-armed in the done cycle
        load_byte(8'h5A);
        arm();
        launch(8'h5A, 0, -1);
        Data_Bus = 8'hF0;
        Load_XMT_datareg = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        arm();
        launch(8'hF0, 0, -1);

        // Random bytes, some with ignored mid-frame loads or T_byte pulses
        for (int i = 0; i < 5; i++) begin
            r = 8'($urandom);
            load_byte(r);
            arm();
            launch(r, int'($urandom_range(0, 2)), int'($urandom_range(1, FRAME_CYCLES - 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
